// File: rtl/alu_pkg.sv
// ALU control codes, queue states and the response record for the ALU responder.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int ALU_W = 32;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic             zero;
        logic             illegal;
    } alu_rsp_t;

    // Occupancy of the 2-entry response queue.
    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_t;

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational MIPS ALU (AND/OR/ADD/SUB/SLT) with zero and illegal-code flags.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            // True signed compare: no overflow artefacts from a - b.
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: illegal = 1'b1;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_resp_unit.sv
// Purpose: valid/ready ALU responder; results captured into a 2-entry response queue.
// Latency: 1 cycle from request accept to response visible on rsp_*.
// Backpressure: req_ready drops only when the queue is full, independent of rsp_ready.
module alu_resp_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal
);

    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_illegal;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a       (req_a),
        .b       (req_b),
        .ctrl    (req_ctrl),
        .result  (core_result),
        .zero    (core_zero),
        .illegal (core_illegal)
    );

    q_state_t         state;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [WIDTH-1:0] res_q [DEPTH];
    logic [DEPTH-1:0] zero_q;
    logic [DEPTH-1:0] illegal_q;

    logic accept;
    logic dequeue;

    assign req_ready = (state != Q_FULL);
    assign rsp_valid = (state != Q_EMPTY);
    assign accept    = req_valid && req_ready;
    assign dequeue   = rsp_valid && rsp_ready;

    // Outputs forced to zero when nothing is queued so stale entries never leak.
    assign rsp_result  = rsp_valid ? res_q[rd_ptr] : '0;
    assign rsp_zero    = rsp_valid && zero_q[rd_ptr];
    assign rsp_illegal = rsp_valid && illegal_q[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= Q_EMPTY;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            zero_q    <= '0;
            illegal_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                res_q[wr_ptr]     <= core_result;
                zero_q[wr_ptr]    <= core_zero;
                illegal_q[wr_ptr] <= core_illegal;
                wr_ptr            <= ~wr_ptr;
            end
            if (dequeue) begin
                rd_ptr <= ~rd_ptr;
            end
            case (state)
                Q_EMPTY: if (accept) state <= Q_ONE;
                Q_ONE: begin
                    if (accept && !dequeue)      state <= Q_FULL;
                    else if (!accept && dequeue) state <= Q_EMPTY;
                end
                Q_FULL:  if (dequeue) state <= Q_ONE;
                default: state <= Q_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_resp_unit.sv
// Directed plus randomized bench for alu_resp_unit against a queue-based reference model.
module tb_alu_resp_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_ctrl;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_illegal;

    int checks   = 0;
    int failures = 0;

    alu_rsp_t mq[$];

    alu_resp_unit #(.WIDTH(32), .DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ctrl    (req_ctrl),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal)
    );

    always #5 clk = ~clk;

    function automatic alu_rsp_t model_op(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
        alu_rsp_t r;
        longint   sa;
        longint   sb;
        longint   sum;
        sa        = longint'($signed(a));
        sb        = longint'($signed(b));
        r.result  = 32'd0;
        r.illegal = 1'b0;
        case (c)
            3'b000: r.result = a & b;
            3'b001: r.result = a | b;
            3'b010: begin sum = longint'(a) + longint'(b); r.result = sum[31:0]; end
            3'b110: begin sum = longint'(a) - longint'(b); r.result = sum[31:0]; end
            3'b111: r.result = (sa < sb) ? 32'd1 : 32'd0;
            default: r.illegal = 1'b1;
        endcase
        r.zero = (r.result == 32'd0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with inputs set; checks at the falling edge,
    // advances the model on the next rising edge and returns 1 time unit later.
    task automatic cycle();
        bit acc;
        bit deq;
        @(negedge clk);
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, mq.size() > 0});
        chk("req_ready", {31'd0, req_ready}, {31'd0, mq.size() < 2});
        if (mq.size() > 0) begin
            chk("rsp_result",  rsp_result, mq[0].result);
            chk("rsp_zero",    {31'd0, rsp_zero}, {31'd0, mq[0].zero});
            chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, mq[0].illegal});
        end else begin
            chk("idle_result", rsp_result, 32'd0);
        end
        acc = req_valid && (mq.size() < 2);
        deq = rsp_ready && (mq.size() > 0);
        @(posedge clk);
        if (deq) void'(mq.pop_front());
        if (acc) mq.push_back(model_op(req_a, req_b, req_ctrl));
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_ctrl  = c;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
    endtask

    // Issue one op with the consumer ready; the new result must be the head right after.
    task automatic op_expect(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] c, input logic [31:0] exp_res,
                             input logic exp_zero, input logic exp_ill);
        req(a, b, c);
        cycle();
        chk({tag, "_res"}, rsp_result, exp_res);
        chk({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, exp_zero});
        chk({tag, "_ill"}, {31'd0, rsp_illegal}, {31'd0, exp_ill});
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        req_ctrl  = 3'd0;
        rsp_ready = 1'b0;
        #12;
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_result", rsp_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back with consumer always ready.
        rsp_ready = 1'b1;
        op_expect("b2b_and", 32'd11, 32'd6, ALU_AND, 32'd2, 1'b0, 1'b0);
        op_expect("b2b_or",  32'd11, 32'd6, ALU_OR,  32'd15, 1'b0, 1'b0);
        op_expect("b2b_add", 32'd8,  32'd6, ALU_ADD, 32'd14, 1'b0, 1'b0);
        op_expect("b2b_sub", 32'd11, 32'd6, ALU_SUB, 32'd5, 1'b0, 1'b0);
        op_expect("b2b_slt", 32'd11, 32'd6, ALU_SLT, 32'd0, 1'b1, 1'b0);
        drain();

        // Backpressure: two fit, third is held until the first pop.
        rsp_ready = 1'b0;
        req(32'd1, 32'd2, ALU_ADD); cycle();
        req(32'd3, 32'd4, ALU_ADD); cycle();
        req(32'd5, 32'd8, ALU_OR);  cycle();
        chk("bp_full_ready", {31'd0, req_ready}, 32'd0);
        chk("bp_hold_head", rsp_result, 32'd3);
        cycle();
        chk("bp_hold_head2", rsp_result, 32'd3);
        rsp_ready = 1'b1;
        cycle();
        chk("bp_pop1_head", rsp_result, 32'd7);
        chk("bp_pop1_ready", {31'd0, req_ready}, 32'd1);
        cycle();
        req_valid = 1'b0;
        chk("bp_third_head", rsp_result, 32'd13);
        drain();

        // Boundary arithmetic.
        op_expect("add_wrap", 32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'd0, 1'b1, 1'b0);
        op_expect("sub_wrap", 32'd0, 32'd1, ALU_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0);
        op_expect("slt_neg",  32'h8000_0000, 32'h7FFF_FFFF, ALU_SLT, 32'd1, 1'b0, 1'b0);
        op_expect("slt_pos",  32'h7FFF_FFFF, 32'h8000_0000, ALU_SLT, 32'd0, 1'b1, 1'b0);

        // Illegal code followed by a legal one.
        op_expect("illegal", 32'd5, 32'd3, 3'b100, 32'd0, 1'b1, 1'b1);
        op_expect("post_ill", 32'd5, 32'd3, ALU_ADD, 32'd8, 1'b0, 1'b0);
        drain();

        // ONE state: simultaneous accept and dequeue replaces the head.
        rsp_ready = 1'b0;
        req(32'd20, 32'd1, ALU_SUB); cycle();
        rsp_ready = 1'b1;
        req(32'd20, 32'd2, ALU_ADD); cycle();
        req_valid = 1'b0;
        chk("one_swap_head", rsp_result, 32'd22);
        chk("one_swap_valid", {31'd0, rsp_valid}, 32'd1);
        drain();

        // FULL: request and consumer both active, only the pop happens.
        rsp_ready = 1'b0;
        req(32'd1, 32'd1, ALU_ADD); cycle();
        req(32'd2, 32'd2, ALU_ADD); cycle();
        rsp_ready = 1'b1;
        req(32'd3, 32'd3, ALU_ADD); cycle();
        chk("full_pop_head", rsp_result, 32'd4);
        cycle();
        chk("full_late_head", rsp_result, 32'd6);
        drain();

        // Randomized traffic with corner-biased operands.
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            req_ctrl  = 3'($urandom_range(0, 7));
            req_a     = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            req_b     = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF : $urandom;
            if ($urandom_range(0, 5) == 0) req_b = req_a;
            cycle();
        end
        drain();

        // Asynchronous reset while full.
        rsp_ready = 1'b0;
        req(32'd9, 32'd9, ALU_ADD); cycle();
        req(32'd7, 32'd7, ALU_ADD); cycle();
        req_valid = 1'b0;
        chk("pre_rst_full", {31'd0, req_ready}, 32'd0);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_async_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_async_result", rsp_result, 32'd0);
        mq.delete();
        #13;
        reset = 1'b0;
        @(posedge clk);
        #1;
        req(32'd8, 32'd6, ALU_ADD); cycle();
        req_valid = 1'b0;
        chk("post_rst_head", rsp_result, 32'd14);
        rsp_ready = 1'b1;
        cycle();
        chk("post_rst_empty", {31'd0, rsp_valid}, 32'd0);
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
